// File: rtl/frontend_inst_queue.sv
// frontend_inst_queue
//   Multi-port circular instruction queue between fetch and decode/issue.
//   Up to WRITE_PORT entries are written per cycle (sparse valid masks are
//   compacted in ascending lane order, whole packets only), and up to
//   READ_PORT of the oldest entries are presented per cycle.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush_i         : synchronous clear of all contents
//   write_valid_i   : per-lane write valid mask (holes allowed)
//   write_data_i    : lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   write_ready_o   : free space for a full WRITE_PORT packet
//   read_valid_o    : thermometer code, bit k set when count > k
//   read_data_o     : lane k = k-th oldest entry
//   read_num_i      : entries consumed this cycle (clamped)
//   stall_i         : backend stall, suppresses consumption
//   count_o         : current occupancy
module frontend_inst_queue #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WRITE_PORT = 2,
  parameter int unsigned READ_PORT  = 2,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [WRITE_PORT-1:0]               write_valid_i,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0]    write_data_i,
  output logic                                write_ready_o,
  output logic [READ_PORT-1:0]                read_valid_o,
  output logic [READ_PORT*DATA_WIDTH-1:0]     read_data_o,
  input  logic [$clog2(READ_PORT+1)-1:0]      read_num_i,
  input  logic                                stall_i,
  output logic [$clog2(DEPTH+1)-1:0]          count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_push;
  logic [CNT_W-1:0]      w_n_push;
  logic [CNT_W-1:0]      w_req;
  logic [CNT_W-1:0]      w_n_pop;
  logic [PTR_W-1:0]      w_lane_slot [WRITE_PORT];

  // Ready looks only at registered occupancy; a same-cycle pop does not help.
  assign write_ready_o = (r_count <= CNT_W'(DEPTH - WRITE_PORT));
  assign w_push        = write_ready_o & (|write_valid_i) & ~flush_i;
  assign count_o       = r_count;

  // Compaction: each valid lane lands after all lower-numbered valid lanes.
  always_comb begin
    w_n_push = '0;
    for (int k = 0; k < WRITE_PORT; k++) begin
      w_lane_slot[k] = r_wr_ptr + PTR_W'(w_n_push);
      if (write_valid_i[k]) begin
        w_n_push = w_n_push + CNT_W'(1);
      end
    end
  end

  // Pop amount: clamp to port count and occupancy, zero under stall.
  always_comb begin
    w_req = CNT_W'(read_num_i);
    if (w_req > CNT_W'(READ_PORT)) begin
      w_req = CNT_W'(READ_PORT);
    end
    if (w_req > r_count) begin
      w_req = r_count;
    end
    w_n_pop = stall_i ? '0 : w_req;
  end

  // Pointer and occupancy state; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_pop);
      r_count  <= r_count + (w_push ? w_n_push : '0) - w_n_pop;
    end
  end

  // Entry storage; validity is tracked by r_count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < WRITE_PORT; k++) begin
        if (write_valid_i[k]) begin
          r_mem[w_lane_slot[k]] <= write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read lanes index from the head and wrap naturally through pointer width.
  always_comb begin
    read_valid_o = '0;
    read_data_o  = '0;
    for (int k = 0; k < READ_PORT; k++) begin
      read_valid_o[k] = (r_count > CNT_W'(k));
      read_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr + PTR_W'(k)];
    end
  end

endmodule

// File: tb/tb_frontend_inst_queue.sv
// Self-checking bench for frontend_inst_queue: directed scenarios plus a
// randomized phase, compared against a queue-based reference model.
module tb_frontend_inst_queue;

  localparam int unsigned DW    = 64;
  localparam int unsigned WP    = 2;
  localparam int unsigned RP    = 2;
  localparam int unsigned DEPTH = 8;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [WP-1:0]            wvalid;
  logic [WP*DW-1:0]         wdata;
  logic                     wready;
  logic [RP-1:0]            rvalid;
  logic [RP*DW-1:0]         rdata;
  logic [$clog2(RP+1)-1:0]  rnum;
  logic                     stall;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q[$];

  frontend_inst_queue #(
    .DATA_WIDTH(DW), .WRITE_PORT(WP), .READ_PORT(RP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .write_valid_i(wvalid), .write_data_i(wdata), .write_ready_o(wready),
    .read_valid_o(rvalid), .read_data_o(rdata), .read_num_i(rnum),
    .stall_i(stall), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return rdata[k*DW +: DW];
  endfunction

  // Reference model: the queue contents as a plain FIFO of words.
  always @(posedge clk or negedge rst_n) begin
    int sz;
    int np;
    bit rdy;
    if (!rst_n) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      sz  = model_q.size();
      rdy = (int'(DEPTH) - sz) >= int'(WP);
      np  = stall ? 0 : int'(rnum);
      if (np > int'(RP)) np = RP;
      if (np > sz) np = sz;
      for (int i = 0; i < np; i++) void'(model_q.pop_front());
      if (rdy && (|wvalid)) begin
        for (int k = 0; k < WP; k++)
          if (wvalid[k]) model_q.push_back(wdata[k*DW +: DW]);
      end
    end
  end

  // Monitor: every cycle, compare presented outputs to the model's contents.
  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    chk("mon_count", DW'(count), DW'(sz));
    chk("mon_ready", DW'(wready), DW'((int'(DEPTH) - sz) >= int'(WP)));
    for (int k = 0; k < RP; k++) begin
      chk("mon_valid", DW'(rvalid[k]), DW'(k < sz));
      if (k < sz && rvalid[k]) chk("mon_data", lane(k), model_q[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wvalid = '0;
    rnum   = '0;
    stall  = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic put(input logic [WP-1:0] m, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    wvalid = m;
    wdata[0*DW +: DW] = d0;
    wdata[1*DW +: DW] = d1;
  endtask

  initial begin
    rst_n = 1'b0;
    wdata = '0;
    idle();
    #1;
    chk("reset_count", DW'(count), '0);
    chk("reset_valid", DW'(rvalid), '0);
    chk("reset_ready", DW'(wready), DW'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic fill/drain
    put(2'b11, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B);
    step(); idle();
    chk("t1_valid", DW'(rvalid), DW'(2'b11));
    chk("t1_lane0", lane(0), 64'hAAAA_0000_0000_000A);
    chk("t1_lane1", lane(1), 64'hBBBB_0000_0000_000B);
    rnum = 2; step(); idle();
    chk("t1_drained", DW'(count), '0);

    // Sparse compaction
    put(2'b10, 64'h0, 64'hCCCC_0000_0000_000C); step();
    put(2'b01, 64'hDDDD_0000_0000_000D, 64'h0); step(); idle();
    chk("t2_lane0", lane(0), 64'hCCCC_0000_0000_000C);
    chk("t2_lane1", lane(1), 64'hDDDD_0000_0000_000D);
    chk("t2_count", DW'(count), DW'(2));
    rnum = 2; step(); idle();

    // Full queue, all-or-nothing acceptance
    for (int i = 0; i < 4; i++) begin
      put(2'b11, DW'(100 + 2*i), DW'(101 + 2*i)); step();
    end
    idle();
    chk("t3_full_count", DW'(count), DW'(8));
    chk("t3_full_ready", DW'(wready), '0);
    put(2'b11, 64'hDEAD, 64'hBEEF); rnum = 2; step(); idle();
    chk("t3_drop_count", DW'(count), DW'(6));
    chk("t3_head", lane(0), DW'(102));
    rnum = 2; repeat (3) step(); idle();
    chk("t3_empty", DW'(count), '0);

    // Pointer wrap with sustained throughput
    put(2'b11, DW'(0), DW'(1)); step();
    for (int i = 1; i < 10; i++) begin
      put(2'b11, DW'(2*i), DW'(2*i + 1)); rnum = 2; step();
      chk("t4_count", DW'(count), DW'(2));
      chk("t4_order", lane(0), DW'(2*i));
    end
    idle(); rnum = 2; step(); idle();
    chk("t4_empty", DW'(count), '0);

    // Over-request clamp and stall
    put(2'b01, DW'(55), DW'(0)); step(); idle();
    rnum = 2; step(); idle();
    chk("t5_clamp_count", DW'(count), '0);
    chk("t5_clamp_valid", DW'(rvalid), '0);
    put(2'b11, DW'(60), DW'(61)); step();
    put(2'b01, DW'(62), DW'(0)); step(); idle();
    stall = 1'b1; rnum = 2; step(); idle();
    chk("t5_stall_count", DW'(count), DW'(3));
    rnum = 2; repeat (2) step(); idle();
    chk("t5_empty", DW'(count), '0);

    // Flush priority
    put(2'b11, DW'(70), DW'(71)); step();
    put(2'b11, DW'(72), DW'(73)); step();
    put(2'b01, DW'(74), DW'(0)); step(); idle();
    chk("t6_pre_count", DW'(count), DW'(5));
    put(2'b11, DW'(80), DW'(81)); rnum = 2; flush = 1'b1; step(); idle();
    chk("t6_flush_count", DW'(count), '0);
    chk("t6_flush_valid", DW'(rvalid), '0);
    put(2'b01, 64'hEEEE_0000_0000_000E, DW'(0)); step(); idle();
    chk("t6_after_lane0", lane(0), 64'hEEEE_0000_0000_000E);
    chk("t6_after_count", DW'(count), DW'(1));
    rnum = 2; step(); idle();

    // Asynchronous reset mid-operation
    put(2'b11, DW'(90), DW'(91)); step(); idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_count", DW'(count), '0);
    chk("t7_async_valid", DW'(rvalid), '0);
    chk("t7_async_ready", DW'(wready), DW'(1));
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic; first half favours filling, second half draining
    for (int i = 0; i < 3000; i++) begin
      wvalid = WP'($urandom);
      for (int k = 0; k < WP; k++) wdata[k*DW +: DW] = {$urandom, $urandom};
      rnum  = 2'($urandom_range(0, (i < 1500) ? 1 : 3));
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frontend_inst_queue.md
# frontend_inst_queue

Parametrised multi-port instruction queue between the I-cache fetch stage and the decode/issue stage. It generalises the fixed 2-in/2-out, 4-deep frontend buffers to arbitrary write width, read width and depth. It also adds three behaviours the old buffers lack: sparse valid-mask compaction, all-or-nothing packet acceptance, and an occupancy output. Entries are opaque `DATA_WIDTH` words, so the block serves both the raw-fetch queue and the decoded-instruction queue.

## Interface
- `DATA_WIDTH`, 64 — bits per entry.
- `WRITE_PORT`, 2 — lanes written per cycle (≥1).
- `READ_PORT`, 2 — lanes presented per cycle (≥1).
- `DEPTH`, 8 — entries; power of two, ≥ `WRITE_PORT` + `READ_PORT`.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `flush_i`  in  1  — synchronous clear of all contents (branch redirect).
- `write_valid_i`  in  `WRITE_PORT`  — per-lane valid mask; any bit pattern is legal, including holes.
- `write_data_i`  in  `WRITE_PORT`×`DATA_WIDTH`  — lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `write_ready_o`  out  1  — the queue can accept a full packet this cycle.
- `read_valid_o`  out  `READ_PORT`  — thermometer code; bit k set when the queue holds more than k entries.
- `read_data_o`  out  `READ_PORT`×`DATA_WIDTH`  — lane k is the k-th oldest entry; don't-care when invalid.
- `read_num_i`  in  $clog2(`READ_PORT`+1)  — number of entries consumed this cycle.
- `stall_i`  in  1  — backend stall; when high, nothing is consumed.
- `count_o`  out  $clog2(`DEPTH`+1)  — current occupancy.

## Operation
- Storage: circular buffer of `DEPTH` entries, with head pointer `rd_ptr`, tail pointer `wr_ptr` and a `count` register. Both pointers wrap modulo `DEPTH`.
- Free space: `free` = `DEPTH` − `count`.
- `write_ready_o` = (`free` ≥ `WRITE_PORT`). It depends only on registered state, never on `read_num_i` in the same cycle.
- Push fires when `write_ready_o` & |`write_valid_i` & ~`flush_i`.
  - Valid lanes are compacted in ascending lane order. Example: mask 2'b10 writes lane 1 into `wr_ptr`.
  - `n_push` = popcount(`write_valid_i`).
  - Acceptance is all-or-nothing: partial packets are never accepted.
  - If `write_ready_o` is low, the whole packet is dropped. The upstream stage must hold its data until ready.
- Pop:
  - `n_pop` = `stall_i` ? 0 : min(`read_num_i`, `count`, `READ_PORT`). Over-requests are clamped and never underflow.
  - `rd_ptr` advances by `n_pop`.
- Count update: `count` ← `count` + `n_push` − `n_pop`. Push and pop can occur in the same cycle.
- Read outputs are combinational from the entries at `rd_ptr`+k (mod `DEPTH`), so they wrap across the array end transparently.
- Flush: when `flush_i` is high, the next edge sets `count`=0 and `rd_ptr`=`wr_ptr`=0. Any push and pop in that cycle are ignored. Flush wins over every other event.
- Entry storage is not reset and needs no clear; validity comes from `count` alone.

## Timing
- Reset (async assert, synchronous release): `count`=0, pointers=0. Outputs under reset: `read_valid_o`=0, `count_o`=0, `write_ready_o`=1.
- Write-to-read latency is 1 cycle. A packet pushed at edge t appears on `read_*` after edge t; there is no same-cycle bypass.
- Pop takes effect at the edge. The next oldest entries appear on lane 0 in the following cycle.
- Full boundary: with `free` < `WRITE_PORT`, ready is low even if a pop in the same cycle would free space. This is a deliberate one-cycle bubble to keep the timing path short.
- Empty boundary: `read_valid_o`=0; `read_num_i` is ignored.
- Throughput: at most `WRITE_PORT` pushes and `READ_PORT` pops per cycle.
- `rst_n` asserted mid-operation clears state immediately, independent of `clk`.

## Test plan
- **Reset and basic fill/drain**
  - Stimulus: reset; push {A,B} with mask 2'b11; next cycle `read_num_i`=2.
  - Required response: `read_valid_o`=2'b11 with lane0=A, lane1=B; afterwards `count_o`=0.
- **Sparse-mask compaction**
  - Stimulus: mask 2'b10 with lane1=C; then mask 2'b01 with lane0=D.
  - Required response: lane0=C, lane1=D, `count_o`=2.
- **Full queue and all-or-nothing acceptance**
  - Stimulus: push 2'b11 in each of 4 cycles (DEPTH 8), with no pops; then try one more push with a simultaneous pop of 2.
  - Required response: `count_o` reaches 8 and `write_ready_o`=0. The extra packet is dropped, and `count_o`=6 on the next cycle.
- **Pointer wrap**
  - Stimulus: sustain 2 pushes and 2 pops per cycle for 10 cycles with sequence values 0..19.
  - Required response: the output order is strictly 0,1,2,… across the wrap, and `count_o` stays constant.
- **Stall and over-request clamping**
  - Stimulus: `count`=1, `read_num_i`=2 → then `stall_i`=1, `read_num_i`=2 with `count`=3.
  - Required response: the first case gives `count_o`=0 with no underflow. The stalled case leaves `count_o` unchanged at 3.
- **Flush priority**
  - Stimulus: `count`=5; in the same cycle push 2'b11, `read_num_i`=2 and `flush_i`=1.
  - Required response: next cycle `count_o`=0 and `read_valid_o`=0. A push after that appears at lane0.
